mbs_bus_arbiter: RTL and testbench

Two-master system-bus arbiter for the dual-core MBSsoc. It sits directly upstream of the shared system bus that feeds memory and peripherals and the SoC debug outputs. It takes bus requests from CPU0 and CPU1, grants the bus to one core at a time with round-robin fairness and a bounded hold time, and muxes the owner's address, data and control onto the shared bus. It also produces the per-core `cpu_pause` stall vector.

---
 rtl/mbs_bus_pkg.sv | 16 +
 rtl/mbs_hold_timer.sv | 30 +++
 rtl/mbs_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_mbs_bus_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mbs_bus_pkg.sv
// Shared definitions for the MBSsoc system-bus arbiter and its bus consumers.
package mbs_bus_pkg;

    localparam int MBS_DATA_W  = 32;
    localparam int MBS_ADDR_W  = 32;
    localparam int MBS_CTRL_W  = 32;
    localparam int MBS_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        TURN = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mbs_hold_timer.sv
// Saturating ownership-hold counter; flags expiry once TIMEOUT owned cycles have elapsed.
module mbs_hold_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;

    // Count owned cycles, saturating at TIMEOUT; cleared on entry to and outside ownership.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != SAT_VAL)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expired = (TIMEOUT != 0) && (r_cnt == SAT_VAL);

endmodule

// File: rtl/mbs_bus_arbiter.sv
// Two-master round-robin system-bus arbiter with bounded hold time and a dead TURN cycle between owners.
module mbs_bus_arbiter
    import mbs_bus_pkg::*;
#(
    parameter int DATA_W  = MBS_DATA_W,
    parameter int ADDR_W  = MBS_ADDR_W,
    parameter int CTRL_W  = MBS_CTRL_W,
    parameter int TIMEOUT = MBS_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic              cpu1_en,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_data,
    input  logic [DATA_W-1:0] m1_data,
    input  logic [CTRL_W-1:0] m0_ctrl,
    input  logic [CTRL_W-1:0] m1_ctrl,
    output logic [1:0]        grant,
    output logic [1:0]        cpu_pause,
    output logic [ADDR_W-1:0] addr_bus,
    output logic [DATA_W-1:0] data_bus,
    output logic [CTRL_W-1:0] ctrl_bus,
    output logic [1:0]        arb_state
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    logic       r_last;
    logic [1:0] r_grant;
    logic [1:0] w_req_masked;
    logic       w_own;
    logic       w_expired;

    assign w_req_masked = {req[1] & cpu1_en, req[0]};
    assign w_own        = (r_state == OWN0) || (r_state == OWN1);

    mbs_hold_timer #(.TIMEOUT(TIMEOUT)) u_hold_timer (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clr     (!w_own || (w_next_state != r_state)),
        .i_en      (w_own),
        .o_expired (w_expired)
    );

    // Next-state logic: round-robin pick when the bus is free, release/preempt when owned.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, TURN: begin
                if (w_req_masked == 2'b11) begin
                    w_next_state = r_last ? OWN0 : OWN1;
                end else if (w_req_masked[0]) begin
                    w_next_state = OWN0;
                end else if (w_req_masked[1]) begin
                    w_next_state = OWN1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            OWN0: begin
                if (!w_req_masked[0] || (w_expired && w_req_masked[1])) begin
                    w_next_state = TURN;
                end else begin
                    w_next_state = OWN0;
                end
            end
            OWN1: begin
                // Masked request also covers the forced release when cpu1_en drops.
                if (!w_req_masked[1] || (w_expired && w_req_masked[0])) begin
                    w_next_state = TURN;
                end else begin
                    w_next_state = OWN1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State, registered grant and last-granted core.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_grant <= {w_next_state == OWN1, w_next_state == OWN0};
            if ((w_next_state == OWN0) && (r_state != OWN0)) begin
                r_last <= 1'b0;
            end else if ((w_next_state == OWN1) && (r_state != OWN1)) begin
                r_last <= 1'b1;
            end else begin
                r_last <= r_last;
            end
        end
    end

    // Owner's fields onto the shared bus; zero when nobody owns it.
    always_comb begin
        addr_bus = {ADDR_W{1'b0}};
        data_bus = {DATA_W{1'b0}};
        ctrl_bus = {CTRL_W{1'b0}};
        case (r_state)
            OWN0: begin
                addr_bus = m0_addr;
                data_bus = m0_data;
                ctrl_bus = m0_ctrl;
            end
            OWN1: begin
                addr_bus = m1_addr;
                data_bus = m1_data;
                ctrl_bus = m1_ctrl;
            end
            default: begin
                addr_bus = {ADDR_W{1'b0}};
                data_bus = {DATA_W{1'b0}};
                ctrl_bus = {CTRL_W{1'b0}};
            end
        endcase
    end

    assign grant     = r_grant;
    assign cpu_pause = w_req_masked & ~r_grant;
    assign arb_state = r_state;

endmodule

// File: tb/tb_mbs_bus_arbiter.sv
// Self-checking bench for mbs_bus_arbiter: directed scenarios plus random traffic against an ownership model.
module tb_mbs_bus_arbiter;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [1:0]    req;
    logic          cpu1_en;
    logic [W-1:0]  m0_addr, m1_addr, m0_data, m1_data, m0_ctrl, m1_ctrl;

    logic [1:0]    grant     [2];
    logic [1:0]    cpu_pause [2];
    logic [1:0]    arb_state [2];
    logic [W-1:0]  addr_bus  [2];
    logic [W-1:0]  data_bus  [2];
    logic [W-1:0]  ctrl_bus  [2];

    mbs_bus_arbiter #(.DATA_W(W), .ADDR_W(W), .CTRL_W(W), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .req(req), .cpu1_en(cpu1_en),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_data(m0_data), .m1_data(m1_data),
        .m0_ctrl(m0_ctrl), .m1_ctrl(m1_ctrl),
        .grant(grant[0]), .cpu_pause(cpu_pause[0]), .addr_bus(addr_bus[0]),
        .data_bus(data_bus[0]), .ctrl_bus(ctrl_bus[0]), .arb_state(arb_state[0])
    );

    mbs_bus_arbiter #(.DATA_W(W), .ADDR_W(W), .CTRL_W(W), .TIMEOUT(0)) dut_nt (
        .clk(clk), .rst(rst), .req(req), .cpu1_en(cpu1_en),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_data(m0_data), .m1_data(m1_data),
        .m0_ctrl(m0_ctrl), .m1_ctrl(m1_ctrl),
        .grant(grant[1]), .cpu_pause(cpu_pause[1]), .addr_bus(addr_bus[1]),
        .data_bus(data_bus[1]), .ctrl_bus(ctrl_bus[1]), .arb_state(arb_state[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model per instance: who owns the bus, whether this is the dead gap cycle,
    // how long the owner has held it, and who was granted most recently.
    int m_owner [2];
    bit m_gap   [2];
    int m_held  [2];
    int m_last  [2];
    int m_to    [2] = '{15, 0};

    int run_len, nt_hold, after_state;
    bit done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit [1:0] rm;
        rm = {req[1] & cpu1_en, req[0]};
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_owner[k] = -1; m_gap[k] = 1'b0; m_held[k] = 0; m_last[k] = 1;
            end else if (m_owner[k] >= 0) begin
                int o;
                o = m_owner[k];
                if (!rm[o] || (m_to[k] != 0 && m_held[k] == m_to[k] && rm[1 - o])) begin
                    m_owner[k] = -1; m_gap[k] = 1'b1; m_held[k] = 0;
                end else if (m_held[k] < m_to[k]) begin
                    m_held[k] = m_held[k] + 1;
                end
            end else begin
                m_gap[k] = 1'b0;
                if (rm == 2'b11)   m_owner[k] = 1 - m_last[k];
                else if (rm[0])    m_owner[k] = 0;
                else if (rm[1])    m_owner[k] = 1;
                else               m_owner[k] = -1;
                if (m_owner[k] >= 0) begin
                    m_last[k] = m_owner[k];
                    m_held[k] = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string step);
        bit [1:0] rm, eg;
        logic [31:0] ea, ed, ec;
        int es;
        rm = {req[1] & cpu1_en, req[0]};
        for (int k = 0; k < 2; k++) begin
            eg = (m_owner[k] == 0) ? 2'b01 : (m_owner[k] == 1) ? 2'b10 : 2'b00;
            es = (m_owner[k] == 0) ? 1 : (m_owner[k] == 1) ? 2 : (m_gap[k] ? 3 : 0);
            ea = (m_owner[k] == 0) ? m0_addr : (m_owner[k] == 1) ? m1_addr : 32'd0;
            ed = (m_owner[k] == 0) ? m0_data : (m_owner[k] == 1) ? m1_data : 32'd0;
            ec = (m_owner[k] == 0) ? m0_ctrl : (m_owner[k] == 1) ? m1_ctrl : 32'd0;
            chk($sformatf("%s/u%0d grant", step, k), grant[k], eg);
            chk($sformatf("%s/u%0d state", step, k), arb_state[k], es);
            chk($sformatf("%s/u%0d pause", step, k), cpu_pause[k], rm & ~eg);
            chk($sformatf("%s/u%0d addr", step, k), addr_bus[k], ea);
            chk($sformatf("%s/u%0d data", step, k), data_bus[k], ed);
            chk($sformatf("%s/u%0d ctrl", step, k), ctrl_bus[k], ec);
        end
    endtask

    task automatic cycle(input string step);
        @(posedge clk);
        model_step();
        #1;
        check_all(step);
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; cpu1_en = 1'b1;
        m0_addr = 32'h100; m1_addr = 32'h200; m0_data = 32'hA0A0; m1_data = 32'hB1B1;
        m0_ctrl = 32'h3;   m1_ctrl = 32'h5;
        cycle("reset");
        chk("reset grant", grant[0], 2'b00);
        chk("reset addr", addr_bus[0], 32'd0);
        rst = 1'b0;

        // Single request from IDLE: one-cycle grant, owner's address on the bus.
        req = 2'b01;
        cycle("single");
        chk("single grant", grant[0], 2'b01);
        chk("single addr", addr_bus[0], 32'h100);
        chk("single pause", cpu_pause[0], 2'b00);

        // Tie after reset goes to CPU0, release passes through one dead cycle.
        rst = 1'b1; req = 2'b00; cycle("rst2"); rst = 1'b0;
        req = 2'b11;
        cycle("tie");
        chk("tie grant", grant[0], 2'b01);
        chk("tie pause", cpu_pause[0], 2'b10);
        req = 2'b10;
        cycle("release");
        chk("release state", arb_state[0], 2'd3);
        chk("release bus", addr_bus[0], 32'd0);
        cycle("handover");
        chk("handover grant", grant[0], 2'b10);
        chk("handover addr", addr_bus[0], 32'h200);

        // Preemption after 16 owned cycles with TIMEOUT=15; no preemption with TIMEOUT=0.
        rst = 1'b1; req = 2'b00; cycle("rst3"); rst = 1'b0;
        req = 2'b11;
        run_len = 0; nt_hold = 0; done = 1'b0; after_state = -1;
        for (int i = 0; i < 100; i++) begin
            cycle("timeout");
            if (!done) begin
                if (grant[0] == 2'b01) run_len++;
                else begin done = 1'b1; after_state = int'(arb_state[0]); end
            end
            if (grant[1] == 2'b01) nt_hold++;
        end
        chk("timeout run", run_len, 32'd16);
        chk("timeout turn", after_state, 32'd3);
        chk("no-timeout hold", nt_hold, 32'd100);

        // CPU1 disabled: request ignored; disabling while it owns forces a release.
        rst = 1'b1; req = 2'b00; cycle("rst4"); rst = 1'b0;
        cpu1_en = 1'b0; req = 2'b10;
        cycle("masked");
        chk("masked grant", grant[0], 2'b00);
        chk("masked pause", cpu_pause[0], 2'b00);
        cpu1_en = 1'b1;
        cycle("enabled");
        chk("enabled grant", grant[0], 2'b10);
        cpu1_en = 1'b0;
        cycle("forced");
        chk("forced state", arb_state[0], 2'd3);
        cycle("forced idle");
        chk("forced idle state", arb_state[0], 2'd0);

        // Reset in the middle of CPU1 ownership.
        cpu1_en = 1'b1;
        cycle("own1");
        chk("own1 grant", grant[0], 2'b10);
        rst = 1'b1;
        cycle("midreset");
        chk("midreset grant", grant[0], 2'b00);
        chk("midreset data", data_bus[0], 32'd0);
        chk("midreset state", arb_state[0], 2'd0);
        rst = 1'b0; req = 2'b00;
        cycle("idle");

        // Random traffic: masters mostly follow the handshake, with occasional disables and resets.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (req[c]) begin
                    if (grant[0][c] && $urandom_range(7) == 0) req[c] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    req[c] = 1'b1;
                end
            end
            cpu1_en = ($urandom_range(15) != 0);
            rst     = ($urandom_range(199) == 0);
            m0_addr = $urandom; m1_addr = $urandom;
            m0_data = $urandom; m1_data = $urandom;
            m0_ctrl = $urandom; m1_ctrl = $urandom;
            cycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
